// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: runs a WIDTH-bit operation DIGIT bits per clock, holding the
// carry in a register between digits, with a start/busy/done handshake and NZVC flags.
module alu_digit_serial #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             carry_out
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("alu_digit_serial: DIGIT must evenly divide WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             overflow_q, overflow_d;
    logic             carry_out_q, carry_out_d;

    logic [DIGIT-1:0] a_dig, b_dig, b_eff, dig_res;
    logic [DIGIT:0]   sum_ext;
    logic             msb_cin, is_arith, last;

    always_comb begin
        a_dig    = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        b_dig    = b_q[int'(cnt_q) * DIGIT +: DIGIT];
        b_eff    = (op_q == 3'b011) ? ~b_dig : b_dig;
        sum_ext  = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the digit MSB recovered from the sum bit: s = a ^ b ^ cin.
        msb_cin  = a_dig[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum_ext[DIGIT-1];
        is_arith = (op_q == 3'b010) || (op_q == 3'b011);
        last     = (cnt_q == CW'(N - 1));
        case (op_q)
            3'b000:          dig_res = b_dig;
            3'b010, 3'b011:  dig_res = sum_ext[DIGIT-1:0];
            3'b100:          dig_res = a_dig & b_dig;
            3'b101:          dig_res = a_dig | b_dig;
            3'b110:          dig_res = a_dig ^ b_dig;
            default:         dig_res = a_dig;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        zero_d      = zero_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        carry_out_d = carry_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = cntrl;
                    cnt_d   = '0;
                    carry_d = (cntrl == 3'b011);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_res;
                carry_d = sum_ext[DIGIT];
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    zero_d      = (result_d == '0);
                    negative_d  = result_d[WIDTH-1];
                    overflow_d  = is_arith & (msb_cin ^ sum_ext[DIGIT]);
                    carry_out_d = is_arith & sum_ext[DIGIT];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_alu_digit_serial.sv
// Self-checking bench for alu_digit_serial: directed and random operations on
// DIGIT=8, 64 and 1 instances, compared against a plain-arithmetic reference model.
module tb_alu_digit_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [2:0]  cntrl = '0;
    int          sel = 0;

    logic        start_i [3];
    logic        busy_i  [3];
    logic        done_i  [3];
    logic [63:0] res_i   [3];
    logic        z_i [3], n_i [3], v_i [3], c_i [3];

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    assign start_i[0] = start && (sel == 0);
    assign start_i[1] = start && (sel == 1);
    assign start_i[2] = start && (sel == 2);

    alu_digit_serial #(.WIDTH(64), .DIGIT(8)) dut (
        .clk(clk), .reset(reset), .start(start_i[0]), .a(a), .b(b), .cntrl(cntrl),
        .busy(busy_i[0]), .done(done_i[0]), .result(res_i[0]), .zero(z_i[0]),
        .negative(n_i[0]), .overflow(v_i[0]), .carry_out(c_i[0]));

    alu_digit_serial #(.WIDTH(64), .DIGIT(64)) dut_wide (
        .clk(clk), .reset(reset), .start(start_i[1]), .a(a), .b(b), .cntrl(cntrl),
        .busy(busy_i[1]), .done(done_i[1]), .result(res_i[1]), .zero(z_i[1]),
        .negative(n_i[1]), .overflow(v_i[1]), .carry_out(c_i[1]));

    alu_digit_serial #(.WIDTH(64), .DIGIT(1)) dut_bit (
        .clk(clk), .reset(reset), .start(start_i[2]), .a(a), .b(b), .cntrl(cntrl),
        .busy(busy_i[2]), .done(done_i[2]), .result(res_i[2]), .zero(z_i[2]),
        .negative(n_i[2]), .overflow(v_i[2]), .carry_out(c_i[2]));

    logic        busy_o, done_o, z_o, n_o, v_o, c_o;
    logic [63:0] res_o;
    assign busy_o = busy_i[sel];
    assign done_o = done_i[sel];
    assign res_o  = res_i[sel];
    assign z_o    = z_i[sel];
    assign n_o    = n_i[sel];
    assign v_o    = v_i[sel];
    assign c_o    = c_i[sel];

    function automatic int latency_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 1 : 64;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the operation definitions, using whole-word arithmetic.
    task automatic model(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic z, output logic n,
                         output logic v, output logic c);
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: r = y;
            3'd2: begin
                r = x + y;
                c = (r < x);
                v = (x[63] == y[63]) && (r[63] != x[63]);
            end
            3'd3: begin
                r = x - y;
                c = (x >= y);
                v = (x[63] != y[63]) && (r[63] != x[63]);
            end
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = x;
        endcase
        z = (r == 64'd0);
        n = r[63];
    endtask

    task automatic run_op(input logic [2:0] op, input logic [63:0] av, input logic [63:0] bv,
                          input bit poke, input string tag);
        logic [63:0] er;
        logic ez, en, ev, ec;
        int cyc;
        int busyCnt;
        model(op, av, bv, er, ez, en, ev, ec);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cntrl = op;
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        cyc = 0;
        busyCnt = 0;
        while (done_o !== 1'b1 && cyc < 200) begin
            if (busy_o === 1'b1) busyCnt++;
            if (poke && (cyc == 2 || cyc == 5)) begin
                start = 1'b1;
                cntrl = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "/latency"}, 64'(cyc), 64'(latency_of(sel)));
        chk({tag, "/busy_cycles"}, 64'(busyCnt), 64'(latency_of(sel)));
        chk({tag, "/busy_at_done"}, 64'(busy_o), 64'd0);
        chk({tag, "/result"}, res_o, er);
        chk({tag, "/zero"}, 64'(z_o), 64'(ez));
        chk({tag, "/negative"}, 64'(n_o), 64'(en));
        chk({tag, "/overflow"}, 64'(v_o), 64'(ev));
        chk({tag, "/carry"}, 64'(c_o), 64'(ec));
        @(negedge clk);
        chk({tag, "/done_pulse"}, 64'(done_o), 64'd0);
        chk({tag, "/result_hold"}, res_o, er);
        if (poke) begin
            repeat (8) @(negedge clk);
            chk({tag, "/no_second_done"}, 64'(done_o | busy_o), 64'd0);
            chk({tag, "/result_kept"}, res_o, er);
        end
    endtask

    initial begin
        logic [63:0] pa, pb, er;
        logic ez, en, ev, ec;
        int doneAt[$];

        $display("[TB] starting alu_digit_serial bench");
        #12;
        chk("reset/busy", 64'(busy_o), 64'd0);
        chk("reset/done", 64'(done_o), 64'd0);
        chk("reset/result", res_o, 64'd0);
        chk("reset/flags", 64'({z_o, n_o, v_o, c_o}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        sel = 0;
        run_op(3'b010, 64'd5, 64'd3, 1'b0, "add_5_3");
        run_op(3'b011, 64'd3, 64'd5, 1'b0, "sub_3_5");
        run_op(3'b011, 64'd5, 64'd5, 1'b0, "sub_5_5");
        run_op(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_ovf");
        run_op(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_carry");

        pa = 64'hF0F0_F0F0_F0F0_F0F0;
        pb = 64'hFF00_FF00_FF00_FF00;
        run_op(3'b100, pa, pb, 1'b0, "and");
        run_op(3'b101, pa, pb, 1'b0, "or");
        run_op(3'b110, pa, pb, 1'b0, "xor");
        run_op(3'b000, pa, pb, 1'b0, "pass_b");
        run_op(3'b001, pa, pb, 1'b0, "pass_a");
        run_op(3'b111, pa, pb, 1'b0, "pass_a7");
        run_op(3'b010, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, "ignore_start");

        // Continuous start: accepts should land every N+1 cycles.
        model(3'b010, 64'd100, 64'd23, er, ez, en, ev, ec);
        @(negedge clk);
        a = 64'd100; b = 64'd23; cntrl = 3'b010; start = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done_o === 1'b1) doneAt.push_back(t);
        end
        start = 1'b0;
        chk("cont/done_count", 64'(doneAt.size()), 64'd4);
        if (doneAt.size() >= 3) begin
            chk("cont/period1", 64'(doneAt[1] - doneAt[0]), 64'd9);
            chk("cont/period2", 64'(doneAt[2] - doneAt[1]), 64'd9);
        end
        chk("cont/result", res_o, er);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a = 64'hDEAD_BEEF_0000_1111; b = 64'h1; cntrl = 3'b011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset/busy", 64'(busy_o), 64'd0);
        chk("midreset/done", 64'(done_o), 64'd0);
        chk("midreset/result", res_o, 64'd0);
        chk("midreset/flags", 64'({z_o, n_o, v_o, c_o}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("midreset/no_done", 64'(done_o | busy_o), 64'd0);
        run_op(3'b010, 64'd7, 64'd9, 1'b0, "add_7_9");

        for (int i = 0; i < 20; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
            run_op(3'($urandom_range(0, 7)), ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        sel = 1;
        run_op(3'b010, 64'd5, 64'd3, 1'b0, "wide_add");
        run_op(3'b011, 64'h8000_0000_0000_0000, 64'd1, 1'b0, "wide_sub_ovf");
        run_op(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, "wide_rand");

        sel = 2;
        run_op(3'b010, 64'd5, 64'd3, 1'b0, "bit_add");
        run_op(3'b011, 64'd3, 64'd5, 1'b0, "bit_sub");
        run_op(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "bit_ovf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
